// File: rtl/proc_pipe_if.sv
// proc_pipe_if: handshake bundle between the pipeline sequencer and its input FIFO, stages and output latch
interface proc_pipe_if #(
    parameter int NUM_STAGES = 3,
    parameter int SLOT_W = 2
);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);
    logic                       in_empty_i;
    logic                       in_rd_o;
    logic [SLOT_W-1:0]          in_tag_o;
    logic [NUM_STAGES-1:0]      stg_start_o;
    logic [NUM_STAGES*SLOT_W-1:0] stg_tag_o;
    logic [NUM_STAGES-1:0]      stg_ready_i;
    logic                       out_empty_i;
    logic                       out_wr_o;
    logic [SLOT_W-1:0]          out_tag_o;
    logic [CNT_W-1:0]           inflight_o;
    logic                       busy_o;
    logic                       err_timeout_o;
    modport master (
        input  in_empty_i, stg_ready_i, out_empty_i,
        output in_rd_o, in_tag_o, stg_start_o, stg_tag_o, out_wr_o, out_tag_o, inflight_o, busy_o, err_timeout_o
    );
    modport slave (
        output in_empty_i, stg_ready_i, out_empty_i,
        input  in_rd_o, in_tag_o, stg_start_o, stg_tag_o, out_wr_o, out_tag_o, inflight_o, busy_o, err_timeout_o
    );
endinterface

// File: rtl/proc_pipe_ctrl.sv
// proc_pipe_ctrl: in-order pipeline sequencer driving NUM_STAGES start/ready stages, one tagged packet per stage.
// Define PROC_WATCHDOG_EN to add a per-stage WAIT timeout that drops the packet and pulses err_timeout_o.
module proc_pipe_ctrl #(
    parameter int NUM_STAGES = 3,
    parameter int SLOT_W = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic rst,
    proc_pipe_if.master pp
);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("proc_pipe_ctrl: NUM_STAGES must be >= 1");
    end
    if (2 ** SLOT_W < NUM_STAGES) begin : g_bad_slot_w
        $error("proc_pipe_ctrl: 2**SLOT_W must be >= NUM_STAGES");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("proc_pipe_ctrl: TIMEOUT_CYCLES must be >= 1");
    end

    state_t state_q [NUM_STAGES];
    state_t state_d [NUM_STAGES];
    logic [SLOT_W-1:0] tag_q [NUM_STAGES];
    logic [SLOT_W-1:0] tag_d [NUM_STAGES];
    logic [SLOT_W-1:0] src [NUM_STAGES+1];
    logic [NUM_STAGES:0] free, handoff;
    logic [NUM_STAGES-1:0] leave, timeout, start_q, start_d;
    logic [SLOT_W-1:0] tag_cnt_q, tag_cnt_d, in_tag_q, in_tag_d, out_tag_q, out_tag_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic in_rd_q, in_rd_d, out_wr_q, out_wr_d, busy_q, busy_d, err_q, err_d;
`ifdef PROC_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q [NUM_STAGES];
    logic [WD_W-1:0] wd_d [NUM_STAGES];
`endif

    always_comb begin
        // Freedom ripples from the output latch backward so a whole full pipeline can advance in one edge.
        free[NUM_STAGES] = pp.out_empty_i;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            leave[k] = state_q[k] == DONE && free[k+1];
            free[k] = state_q[k] == IDLE || leave[k];
            handoff[k+1] = leave[k];
            src[k+1] = tag_q[k];
        end
        handoff[0] = !pp.in_empty_i && free[0];
        src[0] = tag_cnt_q;
        inflight_d = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
`ifdef PROC_WATCHDOG_EN
            wd_d[k] = state_q[k] == WAIT ? wd_q[k] + 1'b1 : '0;
            timeout[k] = state_q[k] == WAIT && !pp.stg_ready_i[k] && wd_q[k] == WD_W'(TIMEOUT_CYCLES - 1);
`else
            timeout[k] = 1'b0;
`endif
            state_d[k] = handoff[k] ? START :
                         state_q[k] == START ? WAIT :
                         state_q[k] == WAIT && pp.stg_ready_i[k] ? DONE :
                         timeout[k] || leave[k] ? IDLE : state_q[k];
            tag_d[k] = handoff[k] ? src[k] : tag_q[k];
            start_d[k] = handoff[k];
            inflight_d = inflight_d + CNT_W'(state_d[k] != IDLE);
        end
        tag_cnt_d = handoff[0] ? tag_cnt_q + 1'b1 : tag_cnt_q;
        in_rd_d = handoff[0];
        in_tag_d = tag_cnt_q;
        out_wr_d = handoff[NUM_STAGES];
        out_tag_d = src[NUM_STAGES];
        busy_d = inflight_d != '0;
        err_d = |timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                state_q[k] <= IDLE;
                tag_q[k] <= '0;
`ifdef PROC_WATCHDOG_EN
                wd_q[k] <= '0;
`endif
            end
            start_q <= '0;
            tag_cnt_q <= '0;
            in_rd_q <= 1'b0;
            in_tag_q <= '0;
            out_wr_q <= 1'b0;
            out_tag_q <= '0;
            inflight_q <= '0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q <= tag_d;
`ifdef PROC_WATCHDOG_EN
            wd_q <= wd_d;
`endif
            start_q <= start_d;
            tag_cnt_q <= tag_cnt_d;
            in_rd_q <= in_rd_d;
            in_tag_q <= in_tag_d;
            out_wr_q <= out_wr_d;
            out_tag_q <= out_tag_d;
            inflight_q <= inflight_d;
            busy_q <= busy_d;
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_tag
        assign pp.stg_tag_o[g*SLOT_W +: SLOT_W] = tag_q[g];
    end
    assign pp.stg_start_o = start_q;
    assign pp.in_rd_o = in_rd_q;
    assign pp.in_tag_o = in_tag_q;
    assign pp.out_wr_o = out_wr_q;
    assign pp.out_tag_o = out_tag_q;
    assign pp.inflight_o = inflight_q;
    assign pp.busy_o = busy_q;
    assign pp.err_timeout_o = err_q;
endmodule

// File: tb/tb_proc_pipe_ctrl.sv
// tb_proc_pipe_ctrl: directed bench for proc_pipe_ctrl with a FIFO model and per-stage ready responders
module tb_proc_pipe_ctrl;
    localparam int N = 3;
    localparam int SW = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_pipe_if #(.NUM_STAGES(N), .SLOT_W(SW)) bus ();
    proc_pipe_ctrl #(.NUM_STAGES(N), .SLOT_W(SW), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .pp(bus));

    int passed = 0, failed = 0, total = 0;
    int cyc = 0, pending = 0, peak = 0, min_gap = 1000, err_cnt = 0, err_cyc = 0, rd_cyc = 0, wr_cyc = 0;
    int last_start [N];
    int start_cyc [N];
    int cnt [N];
    bit held = 1'b0;
    logic [N-1:0] stuck = '0;
    int rd_tags [$];
    int wr_tags [$];
    int exp5 [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic queue(input int n);
        pending = n;
        bus.in_empty_i = (n == 0);
    endtask

    // One clock: sample outputs after the edge, then update the FIFO and stage ready models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.in_rd_o) begin
            rd_tags.push_back(int'(bus.in_tag_o));
            rd_cyc = cyc;
            if (pending > 0) pending--;
        end
        if (bus.out_wr_o) begin
            wr_tags.push_back(int'(bus.out_tag_o));
            wr_cyc = cyc;
        end
        if (int'(bus.inflight_o) > peak) peak = int'(bus.inflight_o);
        if (bus.err_timeout_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
        for (int k = 0; k < N; k++) begin
            if (bus.stg_start_o[k]) begin
                if (cyc - last_start[k] < min_gap) min_gap = cyc - last_start[k];
                last_start[k] = cyc;
                start_cyc[k] = cyc;
                cnt[k] = 0;
            end else cnt[k]++;
            bus.stg_ready_i[k] = !stuck[k] && (held || cnt[k] >= 2);
        end
        bus.in_empty_i = (pending == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        queue(0);
        bus.out_empty_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        rd_tags.delete();
        wr_tags.delete();
        for (int k = 0; k < N; k++) last_start[k] = -100;
        peak = 0;
        min_gap = 1000;
    endtask

    task automatic run_until_wr(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && wr_tags.size() < n; i++) step();
        chk(tag, wr_tags.size(), n);
    endtask

    initial begin
        bus.in_empty_i = 1'b1;
        bus.out_empty_i = 1'b1;
        bus.stg_ready_i = '0;
        for (int k = 0; k < N; k++) begin
            last_start[k] = -100;
            cnt[k] = 0;
        end
        do_reset();
        chk("rst_pulses", {bus.in_rd_o, bus.out_wr_o, bus.stg_start_o, bus.busy_o, bus.err_timeout_o}, 0);
        chk("rst_tags", {bus.stg_tag_o, bus.in_tag_o, bus.out_tag_o}, 0);
        chk("rst_inflight", bus.inflight_o, 0);

        // Single packet, ready two cycles after each start.
        held = 1'b0;
        queue(1);
        run_until_wr("t1_wr_seen", 1, 40);
        chk("t1_rd_count", rd_tags.size(), 1);
        chk("t1_rd_tag", rd_tags.size() > 0 ? rd_tags[0] : -1, 0);
        chk("t1_wr_tag", wr_tags.size() > 0 ? wr_tags[0] : -1, 0);
        chk("t1_latency", wr_cyc - rd_cyc, 12);
        chk("t1_start1_ofs", start_cyc[1] - rd_cyc, 4);
        chk("t1_start2_ofs", start_cyc[2] - rd_cyc, 8);
        step();
        chk("t1_idle_inflight", bus.inflight_o, 0);
        chk("t1_idle_busy", bus.busy_o, 0);

        // Four packets, ready held high.
        do_reset();
        held = 1'b1;
        queue(4);
        run_until_wr("t2_wr_seen", 4, 100);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_wr_tag%0d", i), i < wr_tags.size() ? wr_tags[i] : -1, i);
        chk("t2_peak", peak, 3);
        chk("t2_min_gap", min_gap, 3);

        // Output backpressure with five queued, then release.
        do_reset();
        held = 1'b1;
        bus.out_empty_i = 1'b0;
        queue(5);
        repeat (20) step();
        chk("t3_no_wr", wr_tags.size(), 0);
        chk("t3_pops", rd_tags.size(), 3);
        chk("t3_inflight", bus.inflight_o, 3);
        chk("t3_busy", bus.busy_o, 1);
        chk("t3_no_start", bus.stg_start_o, 0);
        chk("t3_stg_tags", bus.stg_tag_o, 6'b00_01_10);
        bus.out_empty_i = 1'b1;
        run_until_wr("t3_wr_seen", 5, 100);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_rd_tag%0d", i), i < rd_tags.size() ? rd_tags[i] : -1, exp5[i]);
            chk($sformatf("t4_wr_tag%0d", i), i < wr_tags.size() ? wr_tags[i] : -1, exp5[i]);
        end

        // Reset with two packets in flight.
        do_reset();
        held = 1'b1;
        queue(2);
        for (int i = 0; i < 20 && rd_tags.size() < 2; i++) step();
        step();
        chk("t5_two_inflight", bus.inflight_o, 2);
        rst = 1'b1;
        step();
        chk("t5_rst_pulses", {bus.in_rd_o, bus.out_wr_o, bus.stg_start_o, bus.busy_o, bus.err_timeout_o}, 0);
        chk("t5_rst_tags", {bus.stg_tag_o, bus.in_tag_o, bus.out_tag_o}, 0);
        chk("t5_rst_inflight", bus.inflight_o, 0);
        rst = 1'b0;
        rd_tags.delete();
        wr_tags.delete();
        queue(1);
        repeat (40) step();
        chk("t5_rd_count", rd_tags.size(), 1);
        chk("t5_rd_tag", rd_tags.size() > 0 ? rd_tags[0] : -1, 0);
        chk("t5_wr_count", wr_tags.size(), 1);
        chk("t5_wr_tag", wr_tags.size() > 0 ? wr_tags[0] : -1, 0);

`ifdef PROC_WATCHDOG_EN
        // Stage 1 never ready: one timeout pulse, packet dropped, next packet completes.
        do_reset();
        held = 1'b0;
        stuck = 3'b010;
        err_cnt = 0;
        queue(1);
        for (int i = 0; i < 100 && err_cnt == 0; i++) step();
        chk("t6_err_seen", err_cnt, 1);
        chk("t6_err_delay", err_cyc - start_cyc[1], 17);
        stuck = '0;
        queue(1);
        repeat (40) step();
        chk("t6_err_once", err_cnt, 1);
        chk("t6_wr_count", wr_tags.size(), 1);
        chk("t6_wr_tag", wr_tags.size() > 0 ? wr_tags[0] : -1, 1);
`else
        chk("no_watchdog_err", err_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
